mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Pipeline stage directly downstream of the execute stage. It holds one instruction while its data-memory AXI4-Lite response is collected (R channel for loads, B channel for stores). It sign/zero-extends load data and flags bus access faults. It then presents the result to write-back and drives the rd_*_MEM bypass signals back into execute.

Parameters:
- none (data width fixed at 32, register address at 6 bits, matching the integer/FP register file)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- valid_in  in  1  execute-stage output valid
- ready_out  out  1  stage can accept from execute
- valid_out  out  1  result valid toward write-back
- ready_in  in  1  write-back ready
- dmem_axi_rdata  in  32  read data
- dmem_axi_rresp  in  2  read response
- dmem_axi_rvalid  in  1  read data valid
- dmem_axi_rready  out  1  read data ready
- dmem_axi_bresp  in  2  write response
- dmem_axi_bvalid  in  1  write response valid
- dmem_axi_bready  out  1  write response ready
- addr_lsb_EX  in  2  bits [1:0] of the issued dmem read/write address
- PC_EX, IR_EX  in  32 each  pass-through
- rd_addr_EX  in  6  destination register
- rd_data_EX  in  32  non-memory result
- rd_access_EX  in  1  writes rd
- wb_src_EX  in  3  result source (SEL_MEM = memory op)
- MEM_op_EX  in  3  MEM_LB/LH/LW/LBU/LHU/SB/SH/SW
- imem_axi_rresp_EX, illegal_inst_EX, maligned_*_EX  in  2/1/1/1/1  exception pass-through
- PC_MEM, IR_MEM  out  32 each  registered pass-through
- rd_addr_MEM  out  6  destination register
- rd_data_MEM  out  32  final result (bypass + write-back)
- rd_access_MEM  out  1  rd write valid; 0 unless valid_out
- imem_axi_rresp_MEM, illegal_inst_MEM, maligned_*_MEM  out  exception pass-through
- load_access_fault_MEM  out  1  rresp != OKAY
- store_access_fault_MEM  out  1  bresp != OKAY

Behaviour:
- States: S_EMPTY, S_WAIT_R, S_WAIT_B, S_FULL.
- Reset (reset=0, asynchronous): state is S_EMPTY; every output register is 0. This includes valid_out, rready, bready and both faults. Any outstanding response is dropped.
- Ready logic: ready_out = (S_EMPTY) || (S_FULL && ready_in). ready_out is 0 in both WAIT states, which stalls execute.
- Capture when valid_in && ready_out:
  - All *_EX fields are registered.
  - wb_src_EX==SEL_MEM with rd_access_EX=1 goes to S_WAIT_R.
  - wb_src_EX==SEL_MEM with rd_access_EX=0 goes to S_WAIT_B.
  - Any other instruction goes to S_FULL with rd_data_MEM=rd_data_EX.
- S_WAIT_R:
  - rready=1.
  - On rvalid: rd_data_MEM = extend(rdata >> 8*addr_lsb); load_access_fault = (rresp!=2'b00); go to S_FULL.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata unchanged.
- S_WAIT_B:
  - bready=1.
  - On bvalid: store_access_fault = (bresp!=2'b00); go to S_FULL.
- rready and bready are registered. They assert the cycle after capture and deassert the cycle after the handshake.
- A response may already be pending (rvalid/bvalid held high by the slave) before capture. It is consumed in the first WAIT cycle.
- S_FULL && ready_in:
  - If valid_in, capture the new instruction (back-to-back, no bubble).
  - Otherwise go to S_EMPTY and clear all *_MEM fields to 0.
- S_FULL && !ready_in: hold all outputs stable.
- Latency: non-memory ops take 1 cycle. Memory ops take (cycles until handshake) + 1.
- Exception pass-through fields do not suppress the wait. The bus access is still completed.
- rd_access_MEM = valid_out && registered rd_access. rd_access_MEM is never asserted while in a WAIT state.
- A fault does not change rd_data_MEM gating. Write-back decides.

Optional Feature:
- Macro: MEM_STORE_BRESP_WAIT_EN.
- Defined: stores enter S_WAIT_B as specified above, giving precise store faults.
- Undefined:
  - Stores go straight to S_FULL; S_WAIT_B is unused.
  - dmem_axi_bready is tied to 1 out of reset.
  - bresp is ignored and store_access_fault_MEM is constant 0.

Decomposition:
- CPU_pkg: add mem_state_t enum (S_EMPTY/S_WAIT_R/S_WAIT_B/S_FULL) and AXI_RESP_OKAY=2'b00.
- CPU_pkg: reuse the existing SEL_* and MEM_* constants.
- One sub-module, load_extender (combinational): inputs rdata, addr_lsb, MEM_op; output extended 32-bit word.

Test Plan:
- ALU op with rd_data_EX=32'h1234, ready_in=1: valid_out next cycle, rd_data_MEM=32'h1234, rd_access_MEM=1.
- LB with addr_lsb=2'b10, rdata=32'h00800000, rvalid 3 cycles after capture:
  - ready_out=0 for 3 cycles;
  - then rd_data_MEM=32'hFFFFFF80.
- LHU with addr_lsb=2'b10, rdata=32'hBEEF0000: rd_data_MEM=32'h0000BEEF.
- Store with bresp=2'b10:
  - with MEM_STORE_BRESP_WAIT_EN: store_access_fault_MEM=1;
  - without it: valid_out after 1 cycle and fault=0.
- LW captured while rvalid is already high, with ready_in=0 for 2 cycles after completion: data held stable, then back-to-back capture with no bubble.
- reset=0 asserted in S_WAIT_R: valid_out, rready and rd_access_MEM go to 0 immediately; after release, state is S_EMPTY and ready_out=1.

Source files
------------

// File: rtl/CPU_pkg.sv
// Shared CPU constants and types: write-back source selects, memory op
// codes, AXI response codes and the memory-stage state encoding.
package CPU_pkg;

    localparam logic [2:0] SEL_ALU = 3'd0;
    localparam logic [2:0] SEL_MEM = 3'd1;
    localparam logic [2:0] SEL_PC4 = 3'd2;
    localparam logic [2:0] SEL_IMM = 3'd3;
    localparam logic [2:0] SEL_CSR = 3'd4;

    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LH  = 3'd1;
    localparam logic [2:0] MEM_LW  = 3'd2;
    localparam logic [2:0] MEM_LBU = 3'd3;
    localparam logic [2:0] MEM_LHU = 3'd4;
    localparam logic [2:0] MEM_SB  = 3'd5;
    localparam logic [2:0] MEM_SH  = 3'd6;
    localparam logic [2:0] MEM_SW  = 3'd7;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_WAIT_R,
        S_WAIT_B,
        S_FULL
    } mem_state_t;

endpackage

// File: rtl/load_extender.sv
// Aligns load data by the low address bits and sign/zero-extends it.
// Ports: rdata, addr_lsb, MEM_op in; ext_data (32-bit) out.
module load_extender
    import CPU_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lsb,
    input  logic [2:0]  MEM_op,
    output logic [31:0] ext_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted  = rdata >> {addr_lsb, 3'b000};
        ext_data = rdata;
        unique case (MEM_op)
            MEM_LB:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LH:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LBU: ext_data = {24'b0, shifted[7:0]};
            MEM_LHU: ext_data = {16'b0, shifted[15:0]};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction while its dmem AXI4-Lite
// R/B response is collected, extends load data, flags access faults and
// drives write-back plus the rd_*_MEM bypass into execute.
// Ports: clk, reset (async active-low), valid/ready handshakes both sides,
// dmem R/B channels, *_EX inputs, *_MEM outputs.
// Option: MEM_STORE_BRESP_WAIT_EN makes stores wait for the B response.
module mem_stage
    import CPU_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic [31:0] dmem_axi_rdata,
    input  logic [1:0]  dmem_axi_rresp,
    input  logic        dmem_axi_rvalid,
    output logic        dmem_axi_rready,
    input  logic [1:0]  dmem_axi_bresp,
    input  logic        dmem_axi_bvalid,
    output logic        dmem_axi_bready,
    input  logic [1:0]  addr_lsb_EX,
    input  logic [31:0] PC_EX,
    input  logic [31:0] IR_EX,
    input  logic [5:0]  rd_addr_EX,
    input  logic [31:0] rd_data_EX,
    input  logic        rd_access_EX,
    input  logic [2:0]  wb_src_EX,
    input  logic [2:0]  MEM_op_EX,
    input  logic [1:0]  imem_axi_rresp_EX,
    input  logic        illegal_inst_EX,
    input  logic        maligned_inst_EX,
    input  logic        maligned_load_EX,
    input  logic        maligned_store_EX,
    output logic [31:0] PC_MEM,
    output logic [31:0] IR_MEM,
    output logic [5:0]  rd_addr_MEM,
    output logic [31:0] rd_data_MEM,
    output logic        rd_access_MEM,
    output logic [1:0]  imem_axi_rresp_MEM,
    output logic        illegal_inst_MEM,
    output logic        maligned_inst_MEM,
    output logic        maligned_load_MEM,
    output logic        maligned_store_MEM,
    output logic        load_access_fault_MEM,
    output logic        store_access_fault_MEM
);

    mem_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [5:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_access_q, rd_access_d;
    logic [2:0]  mem_op_q, mem_op_d;
    logic [1:0]  addr_lsb_q, addr_lsb_d;
    logic [1:0]  irresp_q, irresp_d;
    logic        illegal_q, illegal_d;
    logic        mal_inst_q, mal_inst_d;
    logic        mal_load_q, mal_load_d;
    logic        mal_store_q, mal_store_d;
    logic        load_fault_q, load_fault_d;
    logic        store_fault_q, store_fault_d;
    logic        rready_q, rready_d;
    logic        bready_q, bready_d;

    logic [31:0] ext_data;
    logic        capture;
    logic        is_mem;

    load_extender u_load_extender (
        .rdata    (dmem_axi_rdata),
        .addr_lsb (addr_lsb_q),
        .MEM_op   (mem_op_q),
        .ext_data (ext_data)
    );

    assign valid_out = (state_q == S_FULL);
    assign ready_out = (state_q == S_EMPTY)
                    || ((state_q == S_FULL) && ready_in);
    assign capture   = valid_in && ready_out;
    assign is_mem    = (wb_src_EX == SEL_MEM);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        rd_addr_d     = rd_addr_q;
        rd_data_d     = rd_data_q;
        rd_access_d   = rd_access_q;
        mem_op_d      = mem_op_q;
        addr_lsb_d    = addr_lsb_q;
        irresp_d      = irresp_q;
        illegal_d     = illegal_q;
        mal_inst_d    = mal_inst_q;
        mal_load_d    = mal_load_q;
        mal_store_d   = mal_store_q;
        load_fault_d  = load_fault_q;
        store_fault_d = store_fault_q;
        rready_d      = rready_q;
`ifdef MEM_STORE_BRESP_WAIT_EN
        bready_d      = bready_q;
`else
        bready_d      = 1'b1;
`endif

        unique case (state_q)
            S_WAIT_R: begin
                if (dmem_axi_rvalid && rready_q) begin
                    rd_data_d    = ext_data;
                    load_fault_d = (dmem_axi_rresp != AXI_RESP_OKAY);
                    rready_d     = 1'b0;
                    state_d      = S_FULL;
                end
            end
            S_WAIT_B: begin
`ifdef MEM_STORE_BRESP_WAIT_EN
                if (dmem_axi_bvalid && bready_q) begin
                    store_fault_d = (dmem_axi_bresp != AXI_RESP_OKAY);
                    bready_d      = 1'b0;
                    state_d       = S_FULL;
                end
`else
                state_d = S_FULL;
`endif
            end
            S_FULL: begin
                // Drained with nothing behind: clear so the bypass
                // never shows a stale result.
                if (ready_in && !valid_in) begin
                    state_d       = S_EMPTY;
                    pc_d          = '0;
                    ir_d          = '0;
                    rd_addr_d     = '0;
                    rd_data_d     = '0;
                    rd_access_d   = 1'b0;
                    mem_op_d      = '0;
                    addr_lsb_d    = '0;
                    irresp_d      = '0;
                    illegal_d     = 1'b0;
                    mal_inst_d    = 1'b0;
                    mal_load_d    = 1'b0;
                    mal_store_d   = 1'b0;
                    load_fault_d  = 1'b0;
                    store_fault_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (capture) begin
            pc_d          = PC_EX;
            ir_d          = IR_EX;
            rd_addr_d     = rd_addr_EX;
            rd_data_d     = rd_data_EX;
            rd_access_d   = rd_access_EX;
            mem_op_d      = MEM_op_EX;
            addr_lsb_d    = addr_lsb_EX;
            irresp_d      = imem_axi_rresp_EX;
            illegal_d     = illegal_inst_EX;
            mal_inst_d    = maligned_inst_EX;
            mal_load_d    = maligned_load_EX;
            mal_store_d   = maligned_store_EX;
            load_fault_d  = 1'b0;
            store_fault_d = 1'b0;
            if (is_mem && rd_access_EX) begin
                state_d  = S_WAIT_R;
                rready_d = 1'b1;
            end else if (is_mem) begin
`ifdef MEM_STORE_BRESP_WAIT_EN
                state_d  = S_WAIT_B;
                bready_d = 1'b1;
`else
                state_d  = S_FULL;
`endif
            end else begin
                state_d = S_FULL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_EMPTY;
            pc_q          <= '0;
            ir_q          <= '0;
            rd_addr_q     <= '0;
            rd_data_q     <= '0;
            rd_access_q   <= 1'b0;
            mem_op_q      <= '0;
            addr_lsb_q    <= '0;
            irresp_q      <= '0;
            illegal_q     <= 1'b0;
            mal_inst_q    <= 1'b0;
            mal_load_q    <= 1'b0;
            mal_store_q   <= 1'b0;
            load_fault_q  <= 1'b0;
            store_fault_q <= 1'b0;
            rready_q      <= 1'b0;
            bready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            rd_addr_q     <= rd_addr_d;
            rd_data_q     <= rd_data_d;
            rd_access_q   <= rd_access_d;
            mem_op_q      <= mem_op_d;
            addr_lsb_q    <= addr_lsb_d;
            irresp_q      <= irresp_d;
            illegal_q     <= illegal_d;
            mal_inst_q    <= mal_inst_d;
            mal_load_q    <= mal_load_d;
            mal_store_q   <= mal_store_d;
            load_fault_q  <= load_fault_d;
            store_fault_q <= store_fault_d;
            rready_q      <= rready_d;
            bready_q      <= bready_d;
        end
    end

`ifndef MEM_STORE_BRESP_WAIT_EN
    // Stores complete without looking at the B channel.
    logic unused_bchan;
    assign unused_bchan = ^{dmem_axi_bvalid, dmem_axi_bresp, store_fault_q};
`endif

    assign PC_MEM                = pc_q;
    assign IR_MEM                = ir_q;
    assign rd_addr_MEM           = rd_addr_q;
    assign rd_data_MEM           = rd_data_q;
    assign rd_access_MEM         = valid_out && rd_access_q;
    assign imem_axi_rresp_MEM    = irresp_q;
    assign illegal_inst_MEM      = illegal_q;
    assign maligned_inst_MEM     = mal_inst_q;
    assign maligned_load_MEM     = mal_load_q;
    assign maligned_store_MEM    = mal_store_q;
    assign load_access_fault_MEM = load_fault_q;
    assign dmem_axi_rready       = rready_q;
    assign dmem_axi_bready       = bready_q;
`ifdef MEM_STORE_BRESP_WAIT_EN
    assign store_access_fault_MEM = store_fault_q;
`else
    assign store_access_fault_MEM = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: scoreboard of expected write-back results,
// popped whenever the stage hands a result to write-back.
module tb_mem_stage;
    import CPU_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_out;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] dmem_axi_rdata;
    logic [1:0]  dmem_axi_rresp;
    logic        dmem_axi_rvalid;
    logic        dmem_axi_rready;
    logic [1:0]  dmem_axi_bresp;
    logic        dmem_axi_bvalid;
    logic        dmem_axi_bready;
    logic [1:0]  addr_lsb_EX;
    logic [31:0] PC_EX;
    logic [31:0] IR_EX;
    logic [5:0]  rd_addr_EX;
    logic [31:0] rd_data_EX;
    logic        rd_access_EX;
    logic [2:0]  wb_src_EX;
    logic [2:0]  MEM_op_EX;
    logic [1:0]  imem_axi_rresp_EX;
    logic        illegal_inst_EX;
    logic        maligned_inst_EX;
    logic        maligned_load_EX;
    logic        maligned_store_EX;
    logic [31:0] PC_MEM;
    logic [31:0] IR_MEM;
    logic [5:0]  rd_addr_MEM;
    logic [31:0] rd_data_MEM;
    logic        rd_access_MEM;
    logic [1:0]  imem_axi_rresp_MEM;
    logic        illegal_inst_MEM;
    logic        maligned_inst_MEM;
    logic        maligned_load_MEM;
    logic        maligned_store_MEM;
    logic        load_access_fault_MEM;
    logic        store_access_fault_MEM;

    mem_stage dut (
        .clk                    (clk),
        .reset                  (reset),
        .valid_in               (valid_in),
        .ready_out              (ready_out),
        .valid_out              (valid_out),
        .ready_in               (ready_in),
        .dmem_axi_rdata         (dmem_axi_rdata),
        .dmem_axi_rresp         (dmem_axi_rresp),
        .dmem_axi_rvalid        (dmem_axi_rvalid),
        .dmem_axi_rready        (dmem_axi_rready),
        .dmem_axi_bresp         (dmem_axi_bresp),
        .dmem_axi_bvalid        (dmem_axi_bvalid),
        .dmem_axi_bready        (dmem_axi_bready),
        .addr_lsb_EX            (addr_lsb_EX),
        .PC_EX                  (PC_EX),
        .IR_EX                  (IR_EX),
        .rd_addr_EX             (rd_addr_EX),
        .rd_data_EX             (rd_data_EX),
        .rd_access_EX           (rd_access_EX),
        .wb_src_EX              (wb_src_EX),
        .MEM_op_EX              (MEM_op_EX),
        .imem_axi_rresp_EX      (imem_axi_rresp_EX),
        .illegal_inst_EX        (illegal_inst_EX),
        .maligned_inst_EX       (maligned_inst_EX),
        .maligned_load_EX       (maligned_load_EX),
        .maligned_store_EX      (maligned_store_EX),
        .PC_MEM                 (PC_MEM),
        .IR_MEM                 (IR_MEM),
        .rd_addr_MEM            (rd_addr_MEM),
        .rd_data_MEM            (rd_data_MEM),
        .rd_access_MEM          (rd_access_MEM),
        .imem_axi_rresp_MEM     (imem_axi_rresp_MEM),
        .illegal_inst_MEM       (illegal_inst_MEM),
        .maligned_inst_MEM      (maligned_inst_MEM),
        .maligned_load_MEM      (maligned_load_MEM),
        .maligned_store_MEM     (maligned_store_MEM),
        .load_access_fault_MEM  (load_access_fault_MEM),
        .store_access_fault_MEM (store_access_fault_MEM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        acc;
        logic        lf;
        logic        sf;
        logic [5:0]  exc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic send(input logic [31:0] pc,
                        input logic [2:0]  wb,
                        input logic [2:0]  op,
                        input logic        acc,
                        input logic [31:0] data,
                        input logic [1:0]  lsb,
                        input logic [5:0]  exc);
        bit ok;
        ok                = 1'b0;
        PC_EX             = pc;
        IR_EX             = ~pc;
        rd_addr_EX        = pc[5:0];
        rd_data_EX        = data;
        rd_access_EX      = acc;
        wb_src_EX         = wb;
        MEM_op_EX         = op;
        addr_lsb_EX       = lsb;
        imem_axi_rresp_EX = exc[5:4];
        illegal_inst_EX   = exc[3];
        maligned_inst_EX  = exc[2];
        maligned_load_EX  = exc[1];
        maligned_store_EX = exc[0];
        valid_in          = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready_out) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accept", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic r_respond(input logic [31:0] d, input logic [1:0] resp);
        bit ok;
        ok              = 1'b0;
        dmem_axi_rdata  = d;
        dmem_axi_rresp  = resp;
        dmem_axi_rvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dmem_axi_rready) begin
                ok = 1'b1;
                break;
            end
        end
        check("r_handshake", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1 dmem_axi_rvalid = 1'b0;
    endtask

`ifdef MEM_STORE_BRESP_WAIT_EN
    task automatic b_respond(input logic [1:0] resp);
        bit ok;
        ok              = 1'b0;
        dmem_axi_bresp  = resp;
        dmem_axi_bvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dmem_axi_bready) begin
                ok = 1'b1;
                break;
            end
        end
        check("b_handshake", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1 dmem_axi_bvalid = 1'b0;
    endtask
`endif

    // Scoreboard: every write-back handshake retires the oldest entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && valid_out && ready_in) begin
                if (q.size() == 0) begin
                    check("sb_unexpected", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("sb_pc", PC_MEM, e.pc);
                    check("sb_data", rd_data_MEM, e.data);
                    check("sb_acc", {31'b0, rd_access_MEM}, {31'b0, e.acc});
                    check("sb_lfault", {31'b0, load_access_fault_MEM},
                          {31'b0, e.lf});
                    check("sb_sfault", {31'b0, store_access_fault_MEM},
                          {31'b0, e.sf});
                    check("sb_exc", {26'b0, imem_axi_rresp_MEM,
                          illegal_inst_MEM, maligned_inst_MEM,
                          maligned_load_MEM, maligned_store_MEM},
                          {26'b0, e.exc});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b0;
        valid_in          = 1'b0;
        ready_in          = 1'b1;
        dmem_axi_rdata    = '0;
        dmem_axi_rresp    = '0;
        dmem_axi_rvalid   = 1'b0;
        dmem_axi_bresp    = '0;
        dmem_axi_bvalid   = 1'b0;
        addr_lsb_EX       = '0;
        PC_EX             = '0;
        IR_EX             = '0;
        rd_addr_EX        = '0;
        rd_data_EX        = '0;
        rd_access_EX      = 1'b0;
        wb_src_EX         = SEL_ALU;
        MEM_op_EX         = MEM_LW;
        imem_axi_rresp_EX = '0;
        illegal_inst_EX   = 1'b0;
        maligned_inst_EX  = 1'b0;
        maligned_load_EX  = 1'b0;
        maligned_store_EX = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        check("rst_ready", {31'b0, ready_out}, 32'd1);
        check("rst_rready", {31'b0, dmem_axi_rready}, 32'd0);
        check("rst_bready", {31'b0, dmem_axi_bready}, 32'd0);
        check("rst_data", rd_data_MEM, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // ALU op: one-cycle latency.
        q.push_back('{32'h100, 32'h1234, 1'b1, 1'b0, 1'b0, 6'b0});
        send(32'h100, SEL_ALU, MEM_LW, 1'b1, 32'h1234, 2'b00, 6'b0);
        @(negedge clk);
        check("alu_latency", {31'b0, valid_out}, 32'd1);
        @(posedge clk);
        #1;

        // LB, byte 2, response three cycles after capture.
        q.push_back('{32'h104, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 6'b0});
        send(32'h104, SEL_MEM, MEM_LB, 1'b1, 32'h0, 2'b10, 6'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lb_stall", {31'b0, ready_out}, 32'd0);
            check("lb_no_acc", {31'b0, rd_access_MEM}, 32'd0);
            @(posedge clk);
            #1;
        end
        dmem_axi_rdata  = 32'h00800000;
        dmem_axi_rresp  = 2'b00;
        dmem_axi_rvalid = 1'b1;
        @(negedge clk);
        check("lb_stall", {31'b0, ready_out}, 32'd0);
        check("lb_rready", {31'b0, dmem_axi_rready}, 32'd1);
        @(posedge clk);
        #1 dmem_axi_rvalid = 1'b0;
        @(negedge clk);
        check("lb_done", {31'b0, valid_out}, 32'd1);
        check("lb_rready_drop", {31'b0, dmem_axi_rready}, 32'd0);
        @(posedge clk);
        #1;

        // LHU upper half.
        q.push_back('{32'h108, 32'h0000BEEF, 1'b1, 1'b0, 1'b0, 6'b0});
        send(32'h108, SEL_MEM, MEM_LHU, 1'b1, 32'h0, 2'b10, 6'b0);
        r_respond(32'hBEEF0000, 2'b00);

        // LW with SLVERR and a pass-through exception: wait still done.
        q.push_back('{32'h10C, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 6'b000010});
        send(32'h10C, SEL_MEM, MEM_LW, 1'b1, 32'h0, 2'b00, 6'b000010);
        r_respond(32'hDEADBEEF, 2'b10);
        repeat (2) @(posedge clk);
        #1;

        // Store with SLVERR.
`ifdef MEM_STORE_BRESP_WAIT_EN
        q.push_back('{32'h110, 32'h55, 1'b0, 1'b0, 1'b1, 6'b100001});
        send(32'h110, SEL_MEM, MEM_SW, 1'b0, 32'h55, 2'b00, 6'b100001);
        b_respond(2'b10);
`else
        q.push_back('{32'h110, 32'h55, 1'b0, 1'b0, 1'b0, 6'b100001});
        dmem_axi_bresp  = 2'b10;
        dmem_axi_bvalid = 1'b1;
        send(32'h110, SEL_MEM, MEM_SW, 1'b0, 32'h55, 2'b00, 6'b100001);
        @(negedge clk);
        check("st_latency", {31'b0, valid_out}, 32'd1);
        check("st_bready", {31'b0, dmem_axi_bready}, 32'd1);
        @(posedge clk);
        #1 dmem_axi_bvalid = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // LW with rvalid already pending, write-back stalled for 2 cycles.
        ready_in        = 1'b0;
        dmem_axi_rdata  = 32'hCAFEF00D;
        dmem_axi_rresp  = 2'b00;
        dmem_axi_rvalid = 1'b1;
        q.push_back('{32'h114, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 6'b0});
        send(32'h114, SEL_MEM, MEM_LW, 1'b1, 32'h0, 2'b01, 6'b0);
        @(negedge clk);
        check("pend_rready", {31'b0, dmem_axi_rready}, 32'd1);
        check("pend_stall", {31'b0, ready_out}, 32'd0);
        @(posedge clk);
        #1 dmem_axi_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold_valid", {31'b0, valid_out}, 32'd1);
            check("hold_data", rd_data_MEM, 32'hCAFEF00D);
            check("hold_ready", {31'b0, ready_out}, 32'd0);
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        q.push_back('{32'h118, 32'h00000777, 1'b1, 1'b0, 1'b0, 6'b0});
        send(32'h118, SEL_ALU, MEM_LW, 1'b1, 32'h777, 2'b00, 6'b0);
        @(negedge clk);
        check("b2b_valid", {31'b0, valid_out}, 32'd1);
        check("b2b_pc", PC_MEM, 32'h118);
        @(posedge clk);
        #1;

        // Reset while waiting on R.
        send(32'h11C, SEL_MEM, MEM_LB, 1'b1, 32'h0, 2'b00, 6'b0);
        @(negedge clk);
        check("wr_rready", {31'b0, dmem_axi_rready}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", {31'b0, valid_out}, 32'd0);
        check("arst_rready", {31'b0, dmem_axi_rready}, 32'd0);
        check("arst_acc", {31'b0, rd_access_MEM}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, ready_out}, 32'd1);
        check("post_rst_valid", {31'b0, valid_out}, 32'd0);
        @(posedge clk);
        #1;

        // Normal operation after reset.
        q.push_back('{32'h120, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 6'b0});
        send(32'h120, SEL_ALU, MEM_LW, 1'b1, 32'hA5A5A5A5, 2'b00, 6'b0);
        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
